// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: command encodings and default sizes.
package stack_pkg;

  typedef enum logic [1:0] {
    CTL_DRAIN = 2'b00,
    CTL_BYTE  = 2'b01,
    CTL_WORD  = 2'b10,
    CTL_SPLIT = 2'b11
  } ctl_e;

  localparam int DATA_W_DEF     = 16;
  localparam int STACK_SIZE_DEF = 3;
  localparam int OCC_W          = 2;
  localparam int STAT_W         = 16;

  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/stack_occ_tracker.sv
// Mirror of the downstream stack depth, advanced by every command code issued.
module stack_occ_tracker
  import stack_pkg::*;
#(
  parameter int STACK_SIZE = STACK_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  ctl_e             code_i,
  output logic [OCC_W-1:0] occ_o,
  output logic             full_o
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(STACK_SIZE);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    unique case (code_i)
      CTL_DRAIN: if (occ_q != '0)      occ_d = occ_q - OCC_W'(1);
      CTL_SPLIT: if (occ_q != OCC_MAX) occ_d = occ_q + OCC_W'(1);
      default:   occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign occ_o  = occ_q;
  assign full_o = (occ_q == OCC_MAX);

endmodule

// File: rtl/stack_ctl_gen.sv
// Stack command generator: turns requests into one registered ctl code per clock.
// Optional statistics counters are built when STACK_CTL_GEN_STATS_EN is defined.
module stack_ctl_gen
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int STACK_SIZE = STACK_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [1:0]            ctl,
  output logic [DATA_WIDTH-1:0] DATA_in,
  input  logic                  o_wait,
  output logic [OCC_W-1:0]      occ,
  output logic                  err
`ifdef STACK_CTL_GEN_STATS_EN
  ,
  output logic [STAT_W-1:0]     issue_cnt,
  output logic [STAT_W-1:0]     stall_cnt
`endif
);

  localparam int HALF_W = DATA_WIDTH / 2;

  logic                  occ_full;
  logic                  accept;
  ctl_e                  code_d;
  ctl_e                  ctl_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  // A SPLIT may only go out while the mirrored stack has room.
  assign in_ready = !((in_op == 2'(CTL_SPLIT)) && occ_full);
  assign accept   = in_valid && in_ready;
  assign code_d   = accept ? ctl_e'(in_op) : CTL_DRAIN;

  always_comb begin
    data_d = data_q;
    unique case (code_d)
      CTL_BYTE:            data_d = {{(DATA_WIDTH - HALF_W){1'b0}}, in_data[HALF_W-1:0]};
      CTL_WORD, CTL_SPLIT: data_d = in_data;
      default:             data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q  <= CTL_DRAIN;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ctl_q  <= code_d;
      data_q <= data_d;
      err_q  <= err_q | o_wait;
    end
  end

  stack_occ_tracker #(
    .STACK_SIZE (STACK_SIZE)
  ) u_occ (
    .clk    (clk),
    .rst    (rst),
    .code_i (code_d),
    .occ_o  (occ),
    .full_o (occ_full)
  );

  assign ctl     = ctl_q;
  assign DATA_in = data_q;
  assign err     = err_q;

`ifdef STACK_CTL_GEN_STATS_EN
  logic [STAT_W-1:0] issue_q;
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      if (code_d != CTL_DRAIN)     issue_q <= stat_sat_inc(issue_q);
      if (in_valid && !in_ready)   stall_q <= stat_sat_inc(stall_q);
    end
  end

  assign issue_cnt = issue_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_stack_ctl_gen.sv
// Scoreboard bench for stack_ctl_gen: randomized and directed requests against a queue-based model.
module tb_stack_ctl_gen;

  localparam int DW = 16;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_op = 2'b00;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [1:0]    ctl;
  logic [DW-1:0] DATA_in;
  logic          o_wait = 1'b0;
  logic [1:0]    occ;
  logic          err;
`ifdef STACK_CTL_GEN_STATS_EN
  logic [15:0]   issue_cnt;
  logic [15:0]   stall_cnt;
`endif

  stack_ctl_gen #(.DATA_WIDTH(DW), .STACK_SIZE(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_op    (in_op),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ctl      (ctl),
    .DATA_in  (DATA_in),
    .o_wait   (o_wait),
    .occ      (occ),
    .err      (err)
`ifdef STACK_CTL_GEN_STATS_EN
    ,
    .issue_cnt(issue_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctl;
    logic [15:0] data;
    logic [1:0]  occ;
    logic        err;
    logic [15:0] ic;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int          m_occ  = 0;
  logic [15:0] m_data = '0;
  logic        m_err  = 1'b0;
  int          m_ic   = 0;
  int          m_sc   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endfunction

  function automatic void model_reset();
    m_occ = 0; m_data = '0; m_err = 1'b0; m_ic = 0; m_sc = 0;
  endfunction

  // Called at a falling edge: drive one cycle of inputs, predict, then move to next falling edge.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [15:0] d, input logic w);
    bit   rdy, acc;
    int   code;
    exp_t e;
    in_valid = v; in_op = op; in_data = d; o_wait = w;
    rdy  = !(op == 2'b11 && m_occ == SS);
    acc  = v && rdy;
    code = acc ? int'(op) : 0;
    if (code == 1)      m_data = {8'h00, d[7:0]};
    else if (code >= 2) m_data = d;
    if (code == 0)      m_occ = (m_occ > 0) ? m_occ - 1 : 0;
    else if (code == 3) m_occ = m_occ + 1;
    m_err = m_err | w;
    if (code != 0 && m_ic < 16'hFFFF) m_ic++;
    if (v && !rdy && m_sc < 16'hFFFF) m_sc++;
    e.ctl = 2'(code); e.data = m_data; e.occ = 2'(m_occ); e.err = m_err;
    e.ic = 16'(m_ic); e.sc = 16'(m_sc);
    exp_q.push_back(e);
    #1 check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(negedge clk);
  endtask

  // Asynchronous reset pulse mid-cycle; the pending request is discarded.
  task automatic mid_reset();
    exp_t e;
    #2 rst = 1'b0;
    #1;
    check("rst_ctl", {30'd0, ctl}, 32'd0);
    check("rst_occ", {30'd0, occ}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", {16'd0, DATA_in}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    model_reset();
    e.ctl = 2'b00; e.data = '0; e.occ = 2'b00; e.err = 1'b0; e.ic = '0; e.sc = '0;
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: the DUT presents a new command every clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", {30'd0, ctl}, {30'd0, e.ctl});
        check("DATA_in", {16'd0, DATA_in}, {16'd0, e.data});
        check("occ", {30'd0, occ}, {30'd0, e.occ});
        check("err", {31'd0, err}, {31'd0, e.err});
`ifdef STACK_CTL_GEN_STATS_EN
        check("issue_cnt", {16'd0, issue_cnt}, {16'd0, e.ic});
        check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.sc});
`endif
      end
    end
  end

  initial begin
    logic [1:0] rop;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", {30'd0, ctl}, 32'd0);
    check("reset_occ", {30'd0, occ}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b1;

    repeat (4) cycle(1'b0, 2'b00, 16'h0000, 1'b0);
    cycle(1'b1, 2'b10, 16'hBEEF, 1'b0);
    cycle(1'b1, 2'b01, 16'h12AB, 1'b0);
    cycle(1'b0, 2'b00, 16'h5555, 1'b0);
    repeat (5) cycle(1'b1, 2'b11, 16'h1234, 1'b0);
    cycle(1'b1, 2'b00, 16'hAAAA, 1'b0);
    cycle(1'b0, 2'b00, 16'h0000, 1'b1);
    repeat (3) cycle(1'b1, 2'b10, 16'h0F0F, 1'b0);
    cycle(1'b1, 2'b11, 16'h4321, 1'b0);
    mid_reset();

    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) rop = 2'b11;
      cycle(1'($urandom_range(0, 3) != 0), rop, 16'($urandom),
            1'($urandom_range(0, 59) == 0));
      if (i == 150) mid_reset();
    end
    cycle(1'b0, 2'b00, 16'h0000, 1'b0);

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
